// File: rtl/arb_mux.sv
// N-to-1 arbitrated multiplexer with a single registered output stage.
// Round-robin or fixed-priority selection; one word per cycle under full throughput.

module arb_mux_checker #(
  parameter int NUM_IN    = 4,
  parameter int SEL_WIDTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_IN-1:0]    valid,
  input logic [NUM_IN-1:0]    ready,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic [SEL_WIDTH-1:0] sel,
  input logic [SEL_WIDTH-1:0] ptr
);

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(ready));

  a_ready_needs_valid: assert property (@(posedge clk) (ready & ~valid) == {NUM_IN{1'b0}});

  a_no_grant_when_full: assert property (@(posedge clk)
    (out_valid && !out_ready) |-> (ready == {NUM_IN{1'b0}}));

  a_no_grant_in_reset: assert property (@(posedge clk) rst |-> (ready == {NUM_IN{1'b0}}));

  a_sel_in_range: assert property (@(posedge clk) int'(sel) < NUM_IN);

  a_ptr_in_range: assert property (@(posedge clk) int'(ptr) < NUM_IN);

endmodule

module arb_mux #(
  parameter  int DATA_WIDTH = 7,
  parameter  int NUM_IN     = 4,
  parameter  int RR_MODE    = 1,
  localparam int SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RI,
  input  logic [NUM_IN*DATA_WIDTH-1:0] Data_DI,
  input  logic [NUM_IN-1:0]            Valid_SI,
  output logic [NUM_IN-1:0]            Ready_SO,
  output logic [DATA_WIDTH-1:0]        Data_DO,
  output logic                         Valid_SO,
  output logic [SEL_WIDTH-1:0]         Sel_DO,
  input  logic                         Ready_SI
);

  localparam int                 SW1      = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH:0] NUM_IN_W = SW1'(NUM_IN);

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic [SEL_WIDTH-1:0]  sel_r;
  logic [SEL_WIDTH-1:0]  ptr_r;

  logic                  free_s;
  logic                  grant_any_s;
  logic                  grant_s;
  logic [SEL_WIDTH-1:0]  grant_idx_s;
  logic [NUM_IN-1:0]     ready_s;
  logic [DATA_WIDTH-1:0] grant_data_s;

  // Channel index arithmetic modulo NUM_IN; inputs are always below NUM_IN.
  function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                    input logic [SEL_WIDTH:0]   off);
    logic [SEL_WIDTH:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NUM_IN_W) begin
      sum = sum - NUM_IN_W;
    end else begin
      sum = sum;
    end
    return sum[SEL_WIDTH-1:0];
  endfunction

  // Output stage can take a new word when empty or being drained this cycle.
  always_comb begin
    free_s = 1'b0;
    if (!valid_r || Ready_SI) begin
      free_s = 1'b1;
    end else begin
      free_s = 1'b0;
    end
  end

  // Scan channels starting at the pointer (round-robin) or at index 0 (fixed).
  always_comb begin
    logic [SEL_WIDTH-1:0] cand_v;
    cand_v      = {SEL_WIDTH{1'b0}};
    grant_any_s = 1'b0;
    grant_idx_s = {SEL_WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (RR_MODE != 0) begin
        cand_v = wrap_add(ptr_r, SW1'(k));
      end else begin
        cand_v = SEL_WIDTH'(k);
      end
      if (!grant_any_s && Valid_SI[cand_v]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_v;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot ready toward the granted channel, suppressed while in reset.
  always_comb begin
    grant_s = 1'b0;
    ready_s = {NUM_IN{1'b0}};
    if (free_s && grant_any_s && !Rst_RI) begin
      grant_s              = 1'b1;
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign grant_data_s = Data_DI[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];

  // Output register and round-robin pointer; reset overrides any transfer.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
      sel_r   <= {SEL_WIDTH{1'b0}};
      ptr_r   <= {SEL_WIDTH{1'b0}};
    end else if (free_s) begin
      if (grant_s) begin
        valid_r <= 1'b1;
        data_r  <= grant_data_s;
        sel_r   <= grant_idx_s;
        if (RR_MODE != 0) begin
          ptr_r <= wrap_add(grant_idx_s, {{SEL_WIDTH{1'b0}}, 1'b1});
        end
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  assign Ready_SO = ready_s;
  assign Data_DO  = data_r;
  assign Valid_SO = valid_r;
  assign Sel_DO   = sel_r;

  arb_mux_checker #(
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_checker (
    .clk       (Clk_CI),
    .rst       (Rst_RI),
    .valid     (Valid_SI),
    .ready     (Ready_SO),
    .out_valid (valid_r),
    .out_ready (Ready_SI),
    .sel       (sel_r),
    .ptr       (ptr_r)
  );

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, bits per data word.
REQ-002 SHALL have parameter NUM_IN, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have parameter RR_MODE, default 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 SHALL define local SEL_WIDTH = $clog2(NUM_IN).
REQ-005 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising clock edge.
REQ-006 Clk_CI  input  1  clock.
REQ-007 Rst_RI  input  1  synchronous active-high reset.
REQ-008 Data_DI  input  NUM_IN*DATA_WIDTH  packed input words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Valid_SI  input  NUM_IN  per-channel valid.
REQ-010 Ready_SO  output  NUM_IN  per-channel ready; one-hot or zero.
REQ-011 Data_DO  output  DATA_WIDTH  registered muxed word.
REQ-012 Valid_SO  output  1  Data_DO holds an unconsumed word.
REQ-013 Sel_DO  output  SEL_WIDTH  index of the channel that produced Data_DO.
REQ-014 Ready_SI  input  1  downstream accepts Data_DO when high with Valid_SO.

Function
REQ-015 Output register SHALL be "free" when Valid_SO=0 or (Valid_SO=1 and Ready_SI=1).
REQ-016 When free and any Valid_SI bit is set, arbiter SHALL grant exactly one channel g with Valid_SI[g]=1; otherwise no grant.
REQ-017 Ready_SO[g] SHALL be 1 only for the granted channel, combinationally; all other bits 0; all bits 0 when not free.
REQ-018 Ready_SO SHALL NOT depend on Valid_SI of non-requesting channels except through arbitration; Ready_SO[i]=1 implies Valid_SI[i]=1.
REQ-019 On a grant, next edge SHALL load Data_DO <= word g, Sel_DO <= g, Valid_SO <= 1 (latency one cycle, input handshake to Valid_SO).
REQ-020 When free with no grant, next edge SHALL set Valid_SO <= 0; Data_DO and Sel_DO hold.
REQ-021 When not free (Valid_SO=1, Ready_SI=0), Data_DO, Sel_DO, Valid_SO SHALL hold.
REQ-022 Simultaneous output consume and new grant in one cycle SHALL sustain one word per cycle with no bubble.
REQ-023 RR_MODE=1: priority pointer P (SEL_WIDTH bits, reset 0); grant = first valid channel scanning P, P+1, ... modulo NUM_IN.
REQ-024 RR_MODE=1: on each grant, P SHALL update to g+1, wrapping NUM_IN-1 -> 0; P holds when no grant.
REQ-025 RR_MODE=0: grant = lowest index with Valid_SI set; P unused.
REQ-026 For non-power-of-two NUM_IN, P and g SHALL never take values >= NUM_IN.
REQ-027 Round-robin SHALL guarantee any continuously valid channel is granted within NUM_IN grants.

Reset
REQ-028 Rst_RI=1 at an edge SHALL force Valid_SO=0, Data_DO=0, Sel_DO=0, P=0, overriding any concurrent grant or consume.
REQ-029 While Rst_RI=1, Ready_SO SHALL be all zero.
REQ-030 Reset asserted mid-transfer SHALL discard the held word; first cycle after deassertion behaves as empty.

Verification
REQ-031 Reset: assert Rst_RI 2 cycles with Valid_SI=4'b1111 -> Ready_SO=0, Valid_SO=0, Data_DO=0, Sel_DO=0.
REQ-032 Round-robin fairness: NUM_IN=4, RR_MODE=1, Valid_SI=4'b1111 held, Ready_SI=1 -> Sel_DO sequence 0,1,2,3,0 on consecutive cycles, Valid_SO continuously 1.
REQ-033 Backpressure: Valid_SO=1 with word 0x2A, Ready_SI=0 for 3 cycles, Valid_SI=4'b0110 -> Ready_SO=0, Data_DO stays 0x2A; Ready_SI=1 -> next channel loaded same edge, no bubble.
REQ-034 Fixed priority: RR_MODE=0, Valid_SI=4'b1010 held, Ready_SI=1 -> Sel_DO always 1; channel 3 never granted.
REQ-035 Non-power-of-two wrap: NUM_IN=3, all valid -> Sel_DO 0,1,2,0; P never 3.
REQ-036 Reset mid-stream: Rst_RI pulse while Valid_SO=1, Sel_DO=2 -> next cycle Valid_SO=0, P=0; first grant afterward goes to lowest valid index.
